// File: rtl/nmea_pkg.sv
// Shared constants for the NMEA RMC extractor: character codes, field map,
// error causes and FSM encoding.
package nmea_pkg;

  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] COMMA  = 8'h2C;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  localparam logic [3:0] F_TIME   = 4'd1;
  localparam logic [3:0] F_STATUS = 4'd2;
  localparam logic [3:0] F_LAT    = 4'd3;
  localparam logic [3:0] F_NS     = 4'd4;
  localparam logic [3:0] F_LON    = 4'd5;
  localparam logic [3:0] F_EW     = 4'd6;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CKSUM    = 3'd1,
    ERR_OVERFLOW = 3'd2,
    ERR_HEX      = 3'd3,
    ERR_EOL      = 3'd4
  } err_code_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TAG    = 3'd1;
  localparam logic [2:0] S_FIELDS = 3'd2;
  localparam logic [2:0] S_SKIP   = 3'd3;
  localparam logic [2:0] S_CK_HI  = 3'd4;
  localparam logic [2:0] S_CK_LO  = 3'd5;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_digit(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

endpackage

// File: rtl/nmea_field_buf.sv
// Append-only byte buffer for one text field; bytes past MAX_LEN are
// dropped and latch the overflow flag until the next clear.
module nmea_field_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [7:0]           din,
  output logic [8*MAX_LEN-1:0] vec,
  output logic [7:0]           len,
  output logic                 ovf
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vec <= '0;
      len <= 8'd0;
      ovf <= 1'b0;
    end else if (wr) begin
      if (len < 8'(MAX_LEN)) begin
        for (int k = 0; k < MAX_LEN; k++)
          if (len == 8'(k)) vec[8*k +: 8] <= din;
        len <= len + 8'd1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmea_rmc_extractor.sv
// RMC sentence parser: captures time/status/lat/lon into shadow buffers and
// commits them atomically once the sentence is complete and valid.
module nmea_rmc_extractor
  import nmea_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter bit REQUIRE_CKSUM = 1'b1,
  parameter bit ANY_TALKER    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_char,
  input  logic                 in_valid,
  output logic [8*MAX_LEN-1:0] time_vec,
  output logic [7:0]           time_len,
  output logic [8*MAX_LEN-1:0] lat_vec,
  output logic [7:0]           lat_len,
  output logic [8*MAX_LEN-1:0] lon_vec,
  output logic [7:0]           lon_len,
  output logic                 sign_lat,
  output logic                 sign_lon,
  output logic                 fix_active,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [2:0]           err_code
);

  logic [2:0] state;
  logic [2:0] tag_cnt;
  logic [3:0] field_idx;
  logic       field_started;
  logic [7:0] csum;
  logic [3:0] ck_hi;
  logic       ck_hi_ok;
  logic       sh_fix, sh_slat, sh_slon;

  logic                 is_dollar, data_byte, tag_char_ok, any_ovf;
  logic                 do_commit;
  logic [4:0]           hex_in;
  err_code_t            rej_code;
  logic [8*MAX_LEN-1:0] t_vec, la_vec, lo_vec;
  logic [7:0]           t_len, la_len, lo_len;
  logic                 t_ovf, la_ovf, lo_ovf;

  assign is_dollar = in_valid && in_char == DOLLAR;
  assign data_byte = in_valid && state == S_FIELDS && in_char != DOLLAR &&
                     in_char != COMMA && in_char != STAR &&
                     in_char != CR && in_char != LF;
  assign hex_in    = hex_digit(in_char);
  assign any_ovf   = t_ovf || la_ovf || lo_ovf;

  nmea_field_buf #(.MAX_LEN(MAX_LEN)) u_time (
    .clk(clk), .rst(rst), .clr(is_dollar),
    .wr(data_byte && field_idx == F_TIME), .din(in_char),
    .vec(t_vec), .len(t_len), .ovf(t_ovf));

  nmea_field_buf #(.MAX_LEN(MAX_LEN)) u_lat (
    .clk(clk), .rst(rst), .clr(is_dollar),
    .wr(data_byte && field_idx == F_LAT), .din(in_char),
    .vec(la_vec), .len(la_len), .ovf(la_ovf));

  nmea_field_buf #(.MAX_LEN(MAX_LEN)) u_lon (
    .clk(clk), .rst(rst), .clr(is_dollar),
    .wr(data_byte && field_idx == F_LON), .din(in_char),
    .vec(lo_vec), .len(lo_len), .ovf(lo_ovf));

  always_comb begin
    tag_char_ok = 1'b0;
    case (tag_cnt)
      3'd0: tag_char_ok = ANY_TALKER || in_char == "G";
      3'd1: tag_char_ok = ANY_TALKER || in_char == "P";
      3'd2: tag_char_ok = in_char == "R";
      3'd3: tag_char_ok = in_char == "M";
      3'd4: tag_char_ok = in_char == "C";
      default: tag_char_ok = 1'b0;
    endcase
  end

  // End-of-sentence verdict; a '$' always wins and restarts silently.
  always_comb begin
    do_commit = 1'b0;
    rej_code  = ERR_NONE;
    if (in_valid && !is_dollar) begin
      if (state == S_CK_LO) begin
        if (!ck_hi_ok || !hex_in[4])            rej_code = ERR_HEX;
        else if ({ck_hi, hex_in[3:0]} != csum)  rej_code = ERR_CKSUM;
        else if (any_ovf)                       rej_code = ERR_OVERFLOW;
        else                                    do_commit = 1'b1;
      end else if (state == S_FIELDS &&
                   (in_char == STAR || in_char == CR || in_char == LF)) begin
        if (!REQUIRE_CKSUM) begin
          if (any_ovf) rej_code = ERR_OVERFLOW;
          else         do_commit = 1'b1;
        end else if (in_char != STAR) begin
          rej_code = ERR_EOL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    frame_err  <= 1'b0;
    if (rst) begin
      state <= S_IDLE;
      tag_cnt <= 3'd0;
      field_idx <= 4'd0;
      field_started <= 1'b0;
      csum <= 8'd0;
      ck_hi <= 4'd0;
      ck_hi_ok <= 1'b0;
      sh_fix <= 1'b0;
      sh_slat <= 1'b0;
      sh_slon <= 1'b0;
      time_vec <= '0;
      time_len <= 8'd0;
      lat_vec <= '0;
      lat_len <= 8'd0;
      lon_vec <= '0;
      lon_len <= 8'd0;
      sign_lat <= 1'b0;
      sign_lon <= 1'b0;
      fix_active <= 1'b0;
      err_code <= 3'd0;
    end else begin
      if (do_commit) begin
        time_vec <= t_vec;
        time_len <= t_len;
        lat_vec <= la_vec;
        lat_len <= la_len;
        lon_vec <= lo_vec;
        lon_len <= lo_len;
        sign_lat <= sh_slat;
        sign_lon <= sh_slon;
        fix_active <= sh_fix;
        frame_done <= 1'b1;
      end
      if (rej_code != ERR_NONE) begin
        frame_err <= 1'b1;
        err_code <= rej_code;
      end
      if (in_valid) begin
        if (in_char == DOLLAR) begin
          state <= S_TAG;
          tag_cnt <= 3'd0;
          csum <= 8'd0;
          sh_fix <= 1'b0;
          sh_slat <= 1'b0;
          sh_slon <= 1'b0;
        end else begin
          case (state)
            S_TAG: begin
              csum <= csum ^ in_char;
              if (in_char == COMMA) begin
                state <= (tag_cnt == 3'd5) ? S_FIELDS : S_SKIP;
                field_idx <= F_TIME;
                field_started <= 1'b0;
              end else if (tag_cnt == 3'd5 || !tag_char_ok) begin
                state <= S_SKIP;
              end else begin
                tag_cnt <= tag_cnt + 3'd1;
              end
            end
            S_FIELDS: begin
              if (in_char == STAR) begin
                state <= REQUIRE_CKSUM ? S_CK_HI : S_IDLE;
              end else if (in_char == CR || in_char == LF) begin
                state <= S_IDLE;
              end else begin
                csum <= csum ^ in_char;
                if (in_char == COMMA) begin
                  if (field_idx != 4'hF) field_idx <= field_idx + 4'd1;
                  field_started <= 1'b0;
                end else begin
                  field_started <= 1'b1;
                  // Only the first byte of a flag field is significant.
                  if (!field_started) begin
                    case (field_idx)
                      F_STATUS: sh_fix  <= in_char == "A";
                      F_NS:     sh_slat <= in_char == "S";
                      F_EW:     sh_slon <= in_char == "W";
                      default: ;
                    endcase
                  end
                end
              end
            end
            S_CK_HI: begin
              ck_hi <= hex_in[3:0];
              ck_hi_ok <= hex_in[4];
              state <= S_CK_LO;
            end
            S_CK_LO: state <= S_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_rmc_extractor.sv
// Directed table-driven bench for nmea_rmc_extractor, with a second instance
// restricted to GP talkers and a third that commits without a checksum.
module tb_nmea_rmc_extractor;

  localparam int MAX_LEN = 16;
  localparam int VW = 8 * MAX_LEN;
  localparam string T1 = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
  localparam string T3 = "$GNRMC,081836,A,3751.65,S,14507.36,W,000.0,360.0,130998,011.3,E";

  logic clk = 1'b0;
  logic rst, in_valid;
  logic [7:0] in_char;

  logic [VW-1:0] time_vec, lat_vec, lon_vec;
  logic [7:0] time_len, lat_len, lon_len;
  logic sign_lat, sign_lon, fix_active, frame_done, frame_err;
  logic [2:0] err_code;

  logic [VW-1:0] g_time_vec, g_lat_vec, g_lon_vec;
  logic [7:0] g_time_len, g_lat_len, g_lon_len;
  logic g_sign_lat, g_sign_lon, g_fix_active, g_frame_done, g_frame_err;
  logic [2:0] g_err_code;

  logic [VW-1:0] n_time_vec, n_lat_vec, n_lon_vec;
  logic [7:0] n_time_len, n_lat_len, n_lon_len;
  logic n_sign_lat, n_sign_lon, n_fix_active, n_frame_done, n_frame_err;
  logic [2:0] n_err_code;

  int errors = 0;
  int checks = 0;
  int done_a = 0, err_a = 0, done_g = 0, err_g = 0, done_n = 0, err_n = 0;
  int both_a = 0;

  always #5 clk = ~clk;

  nmea_rmc_extractor #(.MAX_LEN(MAX_LEN), .REQUIRE_CKSUM(1'b1), .ANY_TALKER(1'b1)) dut (
    .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid),
    .time_vec(time_vec), .time_len(time_len), .lat_vec(lat_vec), .lat_len(lat_len),
    .lon_vec(lon_vec), .lon_len(lon_len), .sign_lat(sign_lat), .sign_lon(sign_lon),
    .fix_active(fix_active), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code));

  nmea_rmc_extractor #(.MAX_LEN(MAX_LEN), .REQUIRE_CKSUM(1'b1), .ANY_TALKER(1'b0)) dut_gp (
    .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid),
    .time_vec(g_time_vec), .time_len(g_time_len), .lat_vec(g_lat_vec), .lat_len(g_lat_len),
    .lon_vec(g_lon_vec), .lon_len(g_lon_len), .sign_lat(g_sign_lat), .sign_lon(g_sign_lon),
    .fix_active(g_fix_active), .frame_done(g_frame_done), .frame_err(g_frame_err),
    .err_code(g_err_code));

  nmea_rmc_extractor #(.MAX_LEN(MAX_LEN), .REQUIRE_CKSUM(1'b0), .ANY_TALKER(1'b1)) dut_nock (
    .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid),
    .time_vec(n_time_vec), .time_len(n_time_len), .lat_vec(n_lat_vec), .lat_len(n_lat_len),
    .lon_vec(n_lon_vec), .lon_len(n_lon_len), .sign_lat(n_sign_lat), .sign_lon(n_sign_lon),
    .fix_active(n_fix_active), .frame_done(n_frame_done), .frame_err(n_frame_err),
    .err_code(n_err_code));

  // Pulse counters, sampled mid-cycle so each one-cycle pulse is seen once.
  always @(negedge clk) begin
    if (frame_done) done_a++;
    if (frame_err) err_a++;
    if (frame_done && frame_err) both_a++;
    if (g_frame_done) done_g++;
    if (g_frame_err) err_g++;
    if (n_frame_done) done_n++;
    if (n_frame_err) err_n++;
  end

  typedef struct {
    string name;
    string body;
    bit add_ck;
    int a_done;
    int a_err;
    logic [2:0] a_code;
    string exp_time;
    string exp_lat;
    string exp_lon;
    bit slat;
    bit slon;
    bit fix;
    int g_done;
    int g_err;
    int n_done;
    int n_err;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [VW-1:0] pack(input string s);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < s.len() && k < MAX_LEN; k++) v[8*k +: 8] = s[k];
    return v;
  endfunction

  // Appends "*hh" computed over the bytes after the last '$'.
  function automatic string with_ck(input string b);
    logic [7:0] x;
    int st;
    x = 8'h00;
    st = 0;
    for (int k = 0; k < b.len(); k++) if (b[k] == "$") st = k;
    for (int k = st + 1; k < b.len(); k++) x = x ^ b[k];
    return {b, "*", $sformatf("%02X", x)};
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    in_char = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_string(input string s, input bit gaps);
    for (int k = 0; k < s.len(); k++) begin
      send_byte(s[k]);
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_fields(input string tag, input string t, input string la, input string lo,
                              input bit slat, input bit slon, input bit fix);
    checkOutput({tag, ":time_vec"}, time_vec, pack(t));
    checkOutput({tag, ":time_len"}, VW'(time_len), VW'(t.len()));
    checkOutput({tag, ":lat_vec"}, lat_vec, pack(la));
    checkOutput({tag, ":lat_len"}, VW'(lat_len), VW'(la.len()));
    checkOutput({tag, ":lon_vec"}, lon_vec, pack(lo));
    checkOutput({tag, ":lon_len"}, VW'(lon_len), VW'(lo.len()));
    checkOutput({tag, ":flags"}, VW'({sign_lat, sign_lon, fix_active}), VW'({slat, slon, fix}));
  endtask

  task automatic applyStimulus(input vec_t v);
    int da, ea, dg, eg, dn, en;
    string s;
    s = v.add_ck ? with_ck(v.body) : v.body;
    da = done_a; ea = err_a; dg = done_g; eg = err_g; dn = done_n; en = err_n;
    send_string(s, 1'b0);
    settle();
    checkOutput({v.name, ":done"}, VW'(done_a - da), VW'(v.a_done));
    checkOutput({v.name, ":err"}, VW'(err_a - ea), VW'(v.a_err));
    if (v.a_err != 0) checkOutput({v.name, ":err_code"}, VW'(err_code), VW'(v.a_code));
    check_fields(v.name, v.exp_time, v.exp_lat, v.exp_lon, v.slat, v.slon, v.fix);
    checkOutput({v.name, ":gp_done"}, VW'(done_g - dg), VW'(v.g_done));
    checkOutput({v.name, ":gp_err"}, VW'(err_g - eg), VW'(v.g_err));
    checkOutput({v.name, ":nock_done"}, VW'(done_n - dn), VW'(v.n_done));
    checkOutput({v.name, ":nock_err"}, VW'(err_n - en), VW'(v.n_err));
  endtask

  initial begin
    string s;
    int bad, d0;

    tbl[0]  = '{"valid_gp", {T1, "*6A"}, 1'b0, 1, 0, 3'd0,
                "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1, 1, 0, 1, 0};
    tbl[1]  = '{"bad_ck", {T1, "*6B"}, 1'b0, 0, 1, 3'd1,
                "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1, 0, 1, 1, 0};
    tbl[2]  = '{"gn_sw", T3, 1'b1, 1, 0, 3'd0,
                "081836", "3751.65", "14507.36", 1'b1, 1'b1, 1'b1, 0, 0, 1, 0};
    tbl[3]  = '{"lat_ovf", "$GPRMC,123520,V,12345678901234567890,N,01131.000,E,,,,,", 1'b1, 0, 1, 3'd2,
                "081836", "3751.65", "14507.36", 1'b1, 1'b1, 1'b1, 0, 1, 0, 1};
    tbl[4]  = '{"empty_flags", "$GPRMC,000001,,4807.038,,01131.000,,,,,,", 1'b1, 1, 0, 3'd0,
                "000001", "4807.038", "01131.000", 1'b0, 1'b0, 1'b0, 1, 0, 1, 0};
    tbl[5]  = '{"lower_hex", {T1, "*6a"}, 1'b0, 1, 0, 3'd0,
                "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1, 1, 0, 1, 0};
    tbl[6]  = '{"nonhex", {T1, "*6G"}, 1'b0, 0, 1, 3'd3,
                "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1, 0, 1, 1, 0};
    tbl[7]  = '{"gga", "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47", 1'b0, 0, 0, 3'd0,
                "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
    tbl[8]  = '{"restart", {"$GPRMC,1111,A,99", T3}, 1'b1, 1, 0, 3'd0,
                "081836", "3751.65", "14507.36", 1'b1, 1'b1, 1'b1, 0, 0, 1, 0};
    tbl[9]  = '{"eol", "$GPRMC,123519,A\r\n", 1'b0, 0, 1, 3'd4,
                "081836", "3751.65", "14507.36", 1'b1, 1'b1, 1'b1, 0, 1, 1, 0};
    tbl[10] = '{"lat_max", "$GPRMC,235959,A,1234567890123456,N,01131.000,E,,,,,", 1'b1, 1, 0, 3'd0,
                "235959", "1234567890123456", "01131.000", 1'b0, 1'b0, 1'b1, 1, 0, 1, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_char = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_fields("reset", "", "", "", 1'b0, 1'b0, 1'b0);
    checkOutput("reset:pulses_code", VW'({frame_done, frame_err, err_code}), '0);
    checkOutput("reset:other_inst",
                VW'({|g_time_vec, |g_lat_vec, |g_lon_vec, |g_time_len, |g_lat_len, |g_lon_len,
                     g_sign_lat, g_sign_lon, g_fix_active, g_frame_done, g_frame_err, |g_err_code,
                     |n_time_vec, |n_lat_vec, |n_lon_vec, |n_time_len, |n_lat_len, |n_lon_len,
                     n_sign_lat, n_sign_lon, n_fix_active, n_frame_done, n_frame_err, |n_err_code}),
                '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) applyStimulus(tbl[i]);

    // frame_done must rise exactly one cycle after the final checksum digit.
    s = {T1, "*6A"};
    bad = 0;
    for (int k = 0; k < s.len(); k++) begin
      send_byte(s[k]);
      if (frame_done !== (k == s.len() - 1)) bad++;
    end
    checkOutput("latency", VW'(bad), '0);
    @(posedge clk);
    #1;
    checkOutput("pulse_width", VW'(frame_done), '0);

    send_string("$GPRMC,1235", 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_fields("mid_rst", "", "", "", 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst:pulses_code", VW'({frame_done, frame_err, err_code}), '0);
    d0 = done_a;
    send_string({T1, "*6A"}, 1'b0);
    settle();
    checkOutput("post_rst:done", VW'(done_a - d0), VW'(1));
    check_fields("post_rst", "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1);

    applyStimulus(tbl[2]);
    d0 = done_a;
    send_string({T1, "*6A"}, 1'b1);
    settle();
    checkOutput("gaps:done", VW'(done_a - d0), VW'(1));
    check_fields("gaps", "123519", "4807.038", "01131.000", 1'b0, 1'b0, 1'b1);

    checkOutput("no_overlap", VW'(both_a), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
